// File: rtl/rubik_scrambler.sv
// Purpose : scramble generator for the rubik core; emits LFSR-derived moves, records
//           them on a stack, replays the inverse sequence and checks done_i afterwards.
// Latency : first move on cmd_o one cycle after start_i; result DONE_LAT+1 cycles after the last undo move.
// Backpressure: none; the core consumes one move per cycle, and start_i/undo_i are gated by state.
// Ports   : clk_i, rst_i (sync, active-low), start_i/len_i (scramble request),
//           undo_i (replay request), done_i (cube solved), cmd_o (move bus),
//           busy_o (emitting/checking), pass_o/fail_o (result after undo).
module rubik_scrambler #(
  parameter int          MAX_LEN  = 32,
  parameter int          LEN_W    = 6,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          DONE_LAT = 1        // must be >= 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             undo_i,
  input  logic             done_i,
  output logic [3:0]       cmd_o,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o
);

  localparam int          CNT_W     = $clog2(MAX_LEN + 1);
  localparam int          IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int          LAT_W     = (DONE_LAT > 1) ? $clog2(DONE_LAT) : 1;
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE, S_SCRAMBLE, S_HOLD, S_UNDO, S_CHECK, S_RESULT
  } state_t;

  state_t           state, state_n;
  logic [15:0]      lfsr, lfsr_n, lfsr_step;
  logic [3:0]       stack [MAX_LEN];
  logic [CNT_W-1:0] sp, sp_n;          // number of stacked moves
  logic [CNT_W-1:0] rem, rem_n;        // scramble moves still to emit after the current one
  logic [LAT_W-1:0] lat_cnt, lat_cnt_n;
  logic [3:0]       cmd_n;
  logic             busy_n, pass_n, fail_n;
  logic             push;
  logic [IDX_W-1:0] push_idx;
  logic [CNT_W-1:0] len_clamp;
  logic [2:0]       face_raw, face_idx;
  logic [3:0]       cand, move, top;

  assign lfsr_step = lfsr[0] ? ({1'b0, lfsr[15:1]} ^ LFSR_MASK) : {1'b0, lfsr[15:1]};
  assign len_clamp = (int'(len_i) > MAX_LEN) ? CNT_W'(MAX_LEN) : CNT_W'(len_i);
  assign top       = stack[IDX_W'(sp - CNT_W'(1))];

  // Candidate move. cmd_o still holds the previous move while scrambling and is 0
  // everywhere else, so it doubles as the "previous move" for cancellation.
  always_comb begin
    face_raw = lfsr[2:0];
    face_idx = (face_raw >= 3'd6) ? (face_raw - 3'd6) : face_raw;
    cand     = {lfsr[3], face_idx + 3'd1};
    move     = (cand == (cmd_o ^ 4'h8)) ? cmd_o : cand;
  end

  always_comb begin
    state_n   = state;
    lfsr_n    = lfsr;
    sp_n      = sp;
    rem_n     = rem;
    lat_cnt_n = lat_cnt;
    cmd_n     = 4'h0;
    pass_n    = pass_o;
    fail_n    = fail_o;
    push      = 1'b0;
    push_idx  = IDX_W'(sp);
    case (state)
      S_IDLE, S_HOLD, S_RESULT: begin
        if (start_i) begin
          // A new scramble discards the old stack and result; LFSR keeps running.
          pass_n = 1'b0;
          fail_n = 1'b0;
          sp_n   = '0;
          if (len_clamp == '0) begin
            state_n = S_HOLD;
          end else begin
            state_n  = S_SCRAMBLE;
            cmd_n    = move;
            push     = 1'b1;
            push_idx = '0;
            sp_n     = CNT_W'(1);
            rem_n    = len_clamp - CNT_W'(1);
            lfsr_n   = lfsr_step;
          end
        end else if (state == S_HOLD && undo_i) begin
          if (sp == '0) begin
            state_n   = S_CHECK;
            lat_cnt_n = LAT_W'(DONE_LAT - 1);
          end else begin
            state_n = S_UNDO;
            cmd_n   = top ^ 4'h8;
            sp_n    = sp - CNT_W'(1);
          end
        end
      end
      S_SCRAMBLE: begin
        if (rem != '0) begin
          cmd_n  = move;
          push   = 1'b1;
          sp_n   = sp + CNT_W'(1);
          rem_n  = rem - CNT_W'(1);
          lfsr_n = lfsr_step;
        end else begin
          state_n = S_HOLD;
        end
      end
      S_UNDO: begin
        if (sp != '0) begin
          cmd_n = top ^ 4'h8;
          sp_n  = sp - CNT_W'(1);
        end else begin
          state_n   = S_CHECK;
          lat_cnt_n = LAT_W'(DONE_LAT - 1);
        end
      end
      S_CHECK: begin
        if (lat_cnt == '0) begin
          state_n = S_RESULT;
          pass_n  = done_i;
          fail_n  = !done_i;
        end else begin
          lat_cnt_n = lat_cnt - LAT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_SCRAMBLE) || (state_n == S_UNDO) || (state_n == S_CHECK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      lfsr    <= SEED_EFF;
      sp      <= '0;
      rem     <= '0;
      lat_cnt <= '0;
      cmd_o   <= 4'h0;
      busy_o  <= 1'b0;
      pass_o  <= 1'b0;
      fail_o  <= 1'b0;
    end else begin
      state   <= state_n;
      lfsr    <= lfsr_n;
      sp      <= sp_n;
      rem     <= rem_n;
      lat_cnt <= lat_cnt_n;
      cmd_o   <= cmd_n;
      busy_o  <= busy_n;
      pass_o  <= pass_n;
      fail_o  <= fail_n;
    end
  end

  // Stack storage carries no reset; the stack pointer alone defines valid contents.
  always_ff @(posedge clk_i) begin
    if (rst_i && push) stack[push_idx] <= cmd_n;
  end

endmodule

// File: tb/tb_rubik_scrambler.sv
module tb_rubik_scrambler;
  localparam int          MAX_LEN  = 32;
  localparam int          LEN_W    = 6;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int          DONE_LAT = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             undo = 1'b0;
  logic             done = 1'b1;
  logic [3:0]       cmd;
  logic             busy, pass, fail;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  logic [3:0]  m_stack[$];   // moves of the current scramble, oldest first
  logic [3:0]  cube[$];      // stand-in cube: reduced word of applied moves
  bit          corrupt_next = 1'b0;

  always #5 clk = ~clk;

  rubik_scrambler #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .SEED(SEED), .DONE_LAT(DONE_LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .undo_i(undo),
    .done_i(done), .cmd_o(cmd), .busy_o(busy), .pass_o(pass), .fail_o(fail)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] model_cand(input logic [15:0] v);
    int f;
    f = (int'(v[2:0]) % 6) + 1;
    return {v[3], f[2:0]};
  endfunction

  function automatic void model_gen(input int n);
    logic [3:0] prev, c, mv;
    m_stack.delete();
    prev = 4'h0;
    for (int i = 0; i < n; i++) begin
      c  = model_cand(m_lfsr);
      mv = (prev != 4'h0 && c == (prev ^ 4'h8)) ? prev : c;
      m_stack.push_back(mv);
      prev   = mv;
      m_lfsr = lfsr_next(m_lfsr);
    end
  endfunction

  // Advance one cycle; afterwards the outputs of the new cycle are visible and the
  // stand-in cube has absorbed the move on cmd (solved = every move cancelled).
  task automatic tick();
    logic [3:0] m;
    @(posedge clk);
    #1;
    m = cmd;
    if (m != 4'h0) begin
      if (corrupt_next) begin
        m = m ^ 4'h8;
        corrupt_next = 1'b0;
      end
      if (cube.size() > 0 && cube[$] == (m ^ 4'h8)) void'(cube.pop_back());
      else cube.push_back(m);
    end
    done = (cube.size() == 0);
  endtask

  task automatic run_scramble(input int n_req, input string tag, input bit with_undo, input bit poke);
    int n;
    logic [3:0] prev;
    n = (n_req > MAX_LEN) ? MAX_LEN : n_req;
    model_gen(n);
    cube.delete();
    done = 1'b1;
    prev = 4'h0;
    len = LEN_W'(n_req);
    start = 1'b1;
    undo = with_undo;
    tick();
    start = 1'b0;
    undo = 1'b0;
    checks++;
    if (pass !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL %s result_clear: pass=%b fail=%b, want 0 0", tag, pass, fail);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (cmd !== m_stack[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s move%0d: cmd=%h busy=%b, want cmd=%h busy=1", tag, i, cmd, busy, m_stack[i]);
      end
      checks++;
      if (!(cmd inside {[4'h1:4'h6], [4'h9:4'hE]}) || (prev != 4'h0 && cmd == (prev ^ 4'h8))) begin
        errors++;
        $display("FAIL %s legal%0d: cmd=%h prev=%h, want legal non-cancelling code", tag, i, cmd, prev);
      end
      prev = cmd;
      if (poke && i == 1) begin
        start = 1'b1;
        undo = 1'b1;
        len = LEN_W'(3);
      end
      tick();
      start = 1'b0;
      undo = 1'b0;
    end
    checks++;
    if (cmd !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s hold: cmd=%h busy=%b, want cmd=0 busy=0", tag, cmd, busy);
    end
  endtask

  task automatic run_undo(input bit exp_pass, input bit corrupt, input string tag);
    int n;
    n = m_stack.size();
    corrupt_next = corrupt && (n > 0);
    undo = 1'b1;
    tick();
    undo = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      checks++;
      if (cmd !== (m_stack[i] ^ 4'h8) || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s inv%0d: cmd=%h busy=%b, want cmd=%h busy=1", tag, i, cmd, busy, m_stack[i] ^ 4'h8);
      end
      tick();
    end
    for (int k = 0; k < DONE_LAT; k++) begin
      checks++;
      if (cmd !== 4'h0 || busy !== 1'b1 || pass !== 1'b0 || fail !== 1'b0) begin
        errors++;
        $display("FAIL %s check%0d: cmd=%h busy=%b pass=%b fail=%b, want 0 1 0 0", tag, k, cmd, busy, pass, fail);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (pass !== exp_pass || fail !== !exp_pass || busy !== 1'b0 || cmd !== 4'h0) begin
        errors++;
        $display("FAIL %s result%0d: pass=%b fail=%b busy=%b cmd=%h, want pass=%b fail=%b busy=0 cmd=0",
                 tag, k, pass, fail, busy, cmd, exp_pass, !exp_pass);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (cmd !== 4'h0 || busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL reset: cmd=%h busy=%b pass=%b fail=%b, want all 0", cmd, busy, pass, fail);
    end
    rst = 1'b1;
    m_lfsr = SEED;
    undo = 1'b1;
    tick();
    undo = 1'b0;
    tick();
    checks++;
    if (cmd !== 4'h0 || busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL idle_undo_ignored: cmd=%h busy=%b pass=%b fail=%b, want all 0", cmd, busy, pass, fail);
    end
  endtask

  task automatic test_basic_pass();
    run_scramble(4, "scr4", 1'b0, 1'b0);
    run_undo(1'b1, 1'b0, "undo4");
  endtask

  task automatic test_corrupt();
    run_scramble(4, "scr4b", 1'b0, 1'b0);
    run_undo(1'b0, 1'b1, "undo4_bad");
  endtask

  task automatic test_clamp();
    run_scramble(40, "scr40", 1'b0, 1'b0);
    run_undo(1'b1, 1'b0, "undo32");
  endtask

  task automatic test_zero_len();
    run_scramble(0, "scr0", 1'b0, 1'b0);
    run_undo(1'b1, 1'b0, "undo0");
  endtask

  task automatic test_reset_mid_undo();
    run_scramble(5, "scr5", 1'b0, 1'b0);
    undo = 1'b1;
    tick();
    undo = 1'b0;
    tick();
    tick();
    checks++;
    if (cmd !== (m_stack[2] ^ 4'h8)) begin
      errors++;
      $display("FAIL abort_third: cmd=%h, want %h", cmd, m_stack[2] ^ 4'h8);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (cmd !== 4'h0 || busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: cmd=%h busy=%b pass=%b fail=%b, want all 0", cmd, busy, pass, fail);
    end
    undo = 1'b1;
    tick();
    undo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (cmd !== 4'h0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_undo_ignored%0d: cmd=%h busy=%b, want 0 0", k, cmd, busy);
      end
      tick();
    end
    m_lfsr = SEED;
    run_scramble(2, "scr2_reseed", 1'b0, 1'b0);
  endtask

  task automatic test_start_wins();
    run_scramble(3, "scr3", 1'b0, 1'b0);
    run_scramble(2, "scr2_start_wins", 1'b1, 1'b0);
    run_undo(1'b1, 1'b0, "undo2_new_only");
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int  n;
      bit  bad;
      n = int'($urandom_range(0, 40));
      bad = ($urandom_range(0, 2) == 0);
      run_scramble(n, "rnd_scr", 1'b0, $urandom_range(0, 1) == 1);
      run_undo(!(bad && n > 0), bad, "rnd_undo");
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_corrupt();
    test_clamp();
    test_zero_len();
    test_reset_mid_undo();
    test_start_wins();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
